// File: rtl/peripheral_seg7capture.sv
// peripheral_seg7capture
// Watches a multiplexed, active-low 7-segment display bus. It waits until the
// enabled digit's pattern has been stable for STABLE_CYCLES samples. It then
// maps the pattern back to its 4-bit code and EXTENDED flag.
// Optional feature: define SEG7CAP_ERRCNT_EN to add err_cnt[7:0]. This is a
// saturating count of illegal-pattern captures.
module peripheral_seg7capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    output logic [4*NUM_DIGITS-1:0] code,
    output logic [NUM_DIGITS-1:0]   ext,
    output logic [NUM_DIGITS-1:0]   valid_dig,
    output logic                    update,
    output logic                    err,
`ifdef SEG7CAP_ERRCNT_EN
    output logic [7:0]              err_cnt,
`endif
    output logic [2:0]              dig_idx
);

    localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        HOLD
    } state_t;

    logic [NUM_DIGITS-1:0] an_meta;
    logic [NUM_DIGITS-1:0] an_s;
    logic [NUM_DIGITS-1:0] an_hold;
    logic [6:0]            seg_meta;
    logic [6:0]            seg_s;
    logic [6:0]            seg_hold;
    state_t                state;
    logic [7:0]            stable_cnt;
    logic [3:0]            zeros;
    logic                  an_valid;
    logic                  pair_changed;
    logic [2:0]            hold_index;
    logic                  dec_ok;
    logic                  dec_ext;
    logic [3:0]            dec_code;

    // Two-flop synchronizer; resets to the idle (all dark, no digit) bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_meta  <= '1;
            an_s     <= '1;
            seg_meta <= '1;
            seg_s    <= '1;
        end else begin
            an_meta  <= an;
            an_s     <= an_meta;
            seg_meta <= seg;
            seg_s    <= seg_meta;
        end
    end

    // A digit is selected only when exactly one anode line is pulled low
    always_comb begin
        zeros = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s[i]) zeros = zeros + 4'd1;
        end
        an_valid     = (zeros == 4'd1);
        pair_changed = (an_s != an_hold) || (seg_s != seg_hold);
    end

    // Index of the digit whose pattern is being settled/captured
    always_comb begin
        hold_index = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_hold[i]) hold_index = 3'(i);
        end
    end

    // Inverse decode table; standard glyphs are listed first so they win
    always_comb begin
        dec_ok   = 1'b1;
        dec_ext  = 1'b0;
        dec_code = 4'h0;
        case (seg_hold)
            7'b1000000: dec_code = 4'h0;
            7'b1111001: dec_code = 4'h1;
            7'b0100100: dec_code = 4'h2;
            7'b0110000: dec_code = 4'h3;
            7'b0011001: dec_code = 4'h4;
            7'b0010010: dec_code = 4'h5;
            7'b0000010: dec_code = 4'h6;
            7'b1111000: dec_code = 4'h7;
            7'b0000000: dec_code = 4'h8;
            7'b0011000: dec_code = 4'h9;
            7'b0001000: dec_code = 4'hA;
            7'b0000011: dec_code = 4'hB;
            7'b1000110: dec_code = 4'hC;
            7'b0100001: dec_code = 4'hD;
            7'b0000110: dec_code = 4'hE;
            7'b0001110: dec_code = 4'hF;
            7'b1001110: begin dec_ext = 1'b1; dec_code = 4'hC; end
            7'b1001000: begin dec_ext = 1'b1; dec_code = 4'h1; end
            7'b0111111: begin dec_ext = 1'b1; dec_code = 4'h5; end
            7'b1111111: begin dec_ext = 1'b1; dec_code = 4'h0; end
            default:    dec_ok = 1'b0;
        endcase
    end

    // Stability FSM with registered capture outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            stable_cnt <= 8'd0;
            an_hold    <= '1;
            seg_hold   <= '1;
            code       <= '0;
            ext        <= '0;
            valid_dig  <= '0;
            update     <= 1'b0;
            err        <= 1'b0;
            dig_idx    <= 3'd0;
        end else begin
            update <= 1'b0;
            err    <= 1'b0;
            if (state == CAPTURE) begin
                dig_idx <= hold_index;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (3'(i) == hold_index) begin
                        if (dec_ok) begin
                            code[4*i +: 4] <= dec_code;
                            ext[i]         <= dec_ext;
                            valid_dig[i]   <= 1'b1;
                        end else begin
                            valid_dig[i]   <= 1'b0;
                        end
                    end
                end
                update <= dec_ok;
                err    <= !dec_ok;
                state  <= HOLD;
            end else if (!an_valid) begin
                state      <= IDLE;
                stable_cnt <= 8'd0;
            end else begin
                case (state)
                    IDLE: begin
                        state      <= SETTLE;
                        stable_cnt <= 8'd1;
                        an_hold    <= an_s;
                        seg_hold   <= seg_s;
                    end
                    SETTLE: begin
                        if (pair_changed) begin
                            stable_cnt <= 8'd1;
                            an_hold    <= an_s;
                            seg_hold   <= seg_s;
                        end else begin
                            stable_cnt <= stable_cnt + 8'd1;
                            if (stable_cnt + 8'd1 == STABLE_LIMIT) state <= CAPTURE;
                        end
                    end
                    HOLD: begin
                        if (pair_changed) begin
                            state      <= SETTLE;
                            stable_cnt <= 8'd1;
                            an_hold    <= an_s;
                            seg_hold   <= seg_s;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        stable_cnt <= 8'd0;
                    end
                endcase
            end
        end
    end

`ifdef SEG7CAP_ERRCNT_EN
    // Saturating count of illegal captures, in step with the err pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (state == CAPTURE && !dec_ok && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_peripheral_seg7capture.sv
// tb_peripheral_seg7capture
// Directed scenarios followed by a randomized run checked against a
// run-length reference model of the capture rules.
module tb_peripheral_seg7capture;

    localparam int ND = 4;
    localparam int SC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an = 4'b1111;
    logic [6:0]  seg = 7'b1111111;
    logic [15:0] code;
    logic [3:0]  ext;
    logic [3:0]  valid_dig;
    logic        update;
    logic        err;
    logic [2:0]  dig_idx;
`ifdef SEG7CAP_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [6:0] std_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    logic [6:0] ext_pat  [4]  = '{7'b1001110, 7'b1001000, 7'b0111111, 7'b1111111};
    logic [3:0] ext_code [4]  = '{4'hC, 4'h1, 4'h5, 4'h0};
    logic [3:0] an_sel   [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    logic [3:0] xa  [1024];
    logic [6:0] xs  [1024];
    int         evk [1100];

    always #5 clk = ~clk;

    peripheral_seg7capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .an        (an),
        .seg       (seg),
        .code      (code),
        .ext       (ext),
        .valid_dig (valid_dig),
        .update    (update),
        .err       (err),
`ifdef SEG7CAP_ERRCNT_EN
        .err_cnt   (err_cnt),
`endif
        .dig_idx   (dig_idx)
    );

    // Returns {legal, extended, code} for a segment pattern
    function automatic logic [5:0] ref_decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (std_tab[i] == p) return {1'b1, 1'b0, 4'(i)};
        for (int i = 0; i < 4; i++) if (ext_pat[i] == p) return {1'b1, 1'b1, ext_code[i]};
        return 6'b0;
    endfunction

    function automatic bit one_low(input logic [3:0] a);
        int z = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) z++;
        return z == 1;
    endfunction

    function automatic int low_index(input logic [3:0] a);
        for (int i = 0; i < 4; i++) if (!a[i]) return i;
        return 0;
    endfunction

    // Holds one bus pair for n cycles and tallies the pulses seen
    task automatic hold_pair(input logic [3:0] a, input logic [6:0] s, input int n,
                             output int ups, output int errs);
        an = a;
        seg = s;
        ups = 0;
        errs = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (update === 1'b1) ups++;
            if (err === 1'b1) errs++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        an = 4'b1111;
        seg = 7'b1111111;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({code, ext, valid_dig, update, err, dig_idx} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got code=%h ext=%b valid=%b upd=%b err=%b idx=%0d, want all zero",
                     code, ext, valid_dig, update, err, dig_idx);
        end
`ifdef SEG7CAP_ERRCNT_EN
        tests_run++;
        if (err_cnt !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_errcnt: got %0d want 0", err_cnt);
        end
`endif
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (update !== 1'b0 || err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_bus_quiet: got upd=%b err=%b want 0 0", update, err);
        end
    endtask

    task automatic test_single_digit();
        int pulses = 0;
        an = 4'b1110;
        seg = 7'b0100100;
        for (int e = 1; e <= 14; e++) begin
            @(posedge clk);
            @(negedge clk);
            tests_run++;
            if (update !== (e == SC + 3) || err !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL latency_edge%0d: got upd=%b err=%b want upd=%b err=0",
                         e, update, err, (e == SC + 3));
            end
            if (update === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses != 1 || code[3:0] !== 4'h2 || ext[0] !== 1'b0 || valid_dig !== 4'b0001 || dig_idx !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL single_digit: got pulses=%0d code=%h ext0=%b valid=%b idx=%0d want 1 2 0 0001 0",
                     pulses, code[3:0], ext[0], valid_dig, dig_idx);
        end
    endtask

    task automatic test_extended_scan();
        int u, er, tu = 0, te = 0;
        for (int d = 0; d < 4; d++) begin
            hold_pair(an_sel[d], ext_pat[d], 8, u, er);
            tu += u;
            te += er;
        end
        tests_run++;
        if (code !== 16'h051C || ext !== 4'b1111 || valid_dig !== 4'b1111 || tu != 4 || te != 0) begin
            tests_failed++;
            $display("[TB] FAIL extended_scan: got code=%h ext=%b valid=%b upd=%0d err=%0d want 051c 1111 1111 4 0",
                     code, ext, valid_dig, tu, te);
        end
    endtask

    task automatic test_precedence();
        int u, er;
        hold_pair(4'b1101, 7'b1111001, 10, u, er);
        tests_run++;
        if (code[7:4] !== 4'h1 || ext[1] !== 1'b0 || dig_idx !== 3'd1 || u != 1 || er != 0) begin
            tests_failed++;
            $display("[TB] FAIL std_precedence: got code=%h ext1=%b idx=%0d upd=%0d err=%0d want 1 0 1 1 0",
                     code[7:4], ext[1], dig_idx, u, er);
        end
    endtask

    task automatic test_error();
        int u, er;
        hold_pair(4'b1011, 7'b1111000, 10, u, er);
        tests_run++;
        if (code[11:8] !== 4'h7 || valid_dig[2] !== 1'b1 || u != 1) begin
            tests_failed++;
            $display("[TB] FAIL preload_7: got code=%h valid2=%b upd=%0d want 7 1 1", code[11:8], valid_dig[2], u);
        end
        hold_pair(4'b1011, 7'b1010101, 10, u, er);
        tests_run++;
        if (er != 1 || u != 0 || dig_idx !== 3'd2 || valid_dig[2] !== 1'b0 || code[11:8] !== 4'h7) begin
            tests_failed++;
            $display("[TB] FAIL illegal_pattern: got err=%0d upd=%0d idx=%0d valid2=%b code=%h want 1 0 2 0 7",
                     er, u, dig_idx, valid_dig[2], code[11:8]);
        end
`ifdef SEG7CAP_ERRCNT_EN
        tests_run++;
        if (err_cnt !== 8'd1) begin
            tests_failed++;
            $display("[TB] FAIL errcnt_one: got %0d want 1", err_cnt);
        end
`endif
    endtask

    task automatic test_no_capture();
        int u, er, tu = 0, te = 0;
        for (int k = 0; k < 10; k++) begin
            hold_pair(4'b1110, (k % 2 == 0) ? 7'b1111001 : 7'b0100100, 3, u, er);
            tu += u;
            te += er;
        end
        tests_run++;
        if (tu != 0 || te != 0) begin
            tests_failed++;
            $display("[TB] FAIL fast_toggle: got upd=%0d err=%0d want 0 0", tu, te);
        end
        hold_pair(4'b1100, 7'b0000000, 15, u, er);
        tests_run++;
        if (u != 0 || er != 0) begin
            tests_failed++;
            $display("[TB] FAIL two_low_an: got upd=%0d err=%0d want 0 0", u, er);
        end
        hold_pair(4'b1111, 7'b0000000, 15, u, er);
        tests_run++;
        if (u != 0 || er != 0) begin
            tests_failed++;
            $display("[TB] FAIL no_low_an: got upd=%0d err=%0d want 0 0", u, er);
        end
    endtask

    task automatic test_reset_mid();
        int u, er;
        int first = 0;
        hold_pair(4'b0111, 7'b0000000, 4, u, er);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({code, ext, valid_dig, update, err, dig_idx} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_clear: got code=%h ext=%b valid=%b upd=%b err=%b idx=%0d, want all zero",
                     code, ext, valid_dig, update, err, dig_idx);
        end
`ifdef SEG7CAP_ERRCNT_EN
        tests_run++;
        if (err_cnt !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_errcnt: got %0d want 0", err_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 20 && first == 0; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (update === 1'b1) first = e;
        end
        tests_run++;
        if (first < SC + 3) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_latency: got first update at edge %0d want >= %0d (0 = none)", first, SC + 3);
        end
        tests_run++;
        if (code[15:12] !== 4'h8 || valid_dig !== 4'b1000) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_capture: got code=%h valid=%b want 8 1000", code[15:12], valid_dig);
        end
    endtask

    task automatic test_random();
        logic [3:0] pa, na, pan;
        logic [6:0] ps, ns, pseg;
        logic [3:0] mcode [4];
        logic       mext [4];
        logic       mvalid [4];
        logic [15:0] ecode;
        logic [3:0]  eext, evalid;
        logic [5:0]  dec;
        int total = 0, len, dig, merr = 0;
        logic exp_upd, exp_err;

        for (int i = 0; i < 1100; i++) evk[i] = 0;
        for (int i = 0; i < 4; i++) begin
            mcode[i] = 4'h0;
            mext[i] = 1'b0;
            mvalid[i] = 1'b0;
        end
        pa = 4'b1111;
        ps = 7'b1111111;
        for (int s = 0; s < 60; s++) begin
            do begin
                na = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : an_sel[$urandom_range(0, 3)];
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: ns = std_tab[$urandom_range(0, 15)];
                    5, 6:          ns = ext_pat[$urandom_range(0, 3)];
                    default:       ns = 7'($urandom);
                endcase
            end while (na == pa && ns == ps);
            len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, SC - 1) : $urandom_range(SC + 1, SC + 6);
            for (int k = 0; k < len; k++) begin
                xa[total + k] = na;
                xs[total + k] = ns;
            end
            if (one_low(na) && len >= SC) evk[total + SC + 2] = 1;
            total += len;
            pa = na;
            ps = ns;
        end
        for (int k = 0; k < 12; k++) begin
            xa[total + k] = 4'b1111;
            xs[total + k] = 7'b1111111;
        end
        total += 12;

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < total; j++) begin
            an = xa[j];
            seg = xs[j];
            @(posedge clk);
            @(negedge clk);
            exp_upd = 1'b0;
            exp_err = 1'b0;
            dig = 0;
            if (evk[j] != 0) begin
                pan = xa[j - SC - 2];
                pseg = xs[j - SC - 2];
                dig = low_index(pan);
                dec = ref_decode(pseg);
                if (dec[5]) begin
                    mcode[dig] = dec[3:0];
                    mext[dig] = dec[4];
                    mvalid[dig] = 1'b1;
                    exp_upd = 1'b1;
                end else begin
                    mvalid[dig] = 1'b0;
                    if (merr < 255) merr++;
                    exp_err = 1'b1;
                end
            end
            tests_run++;
            if (update !== exp_upd || err !== exp_err) begin
                tests_failed++;
                $display("[TB] FAIL rand_pulse_step%0d: got upd=%b err=%b want upd=%b err=%b",
                         j, update, err, exp_upd, exp_err);
            end
            if (evk[j] != 0) begin
                for (int i = 0; i < 4; i++) begin
                    ecode[4*i +: 4] = mcode[i];
                    eext[i] = mext[i];
                    evalid[i] = mvalid[i];
                end
                tests_run++;
                if (dig_idx !== 3'(dig) || code !== ecode || ext !== eext || valid_dig !== evalid) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_capture_step%0d: got idx=%0d code=%h ext=%b valid=%b want idx=%0d code=%h ext=%b valid=%b",
                             j, dig_idx, code, ext, valid_dig, dig, ecode, eext, evalid);
                end
            end
        end
`ifdef SEG7CAP_ERRCNT_EN
        tests_run++;
        if (err_cnt !== 8'(merr)) begin
            tests_failed++;
            $display("[TB] FAIL rand_errcnt: got %0d want %0d", err_cnt, merr);
        end
`endif
    endtask

    // Runs every scenario in order, then reports
    initial begin
        test_reset();
        test_single_digit();
        test_extended_scan();
        test_precedence();
        test_error();
        test_no_capture();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
